// File: rtl/logic_probe_pkg.sv
// Shared types for the logic probe front end: sample classes, edge history, window default.
// Pure declarations; no logic, no latency.
package logic_probe_pkg;

  typedef enum logic [1:0] {
    LVL_FLOAT   = 2'b00,
    LVL_LOW     = 2'b01,
    LVL_HIGH    = 2'b10,
    LVL_INVALID = 2'b11
  } level_t;

  // Most recent solid logic level; FLOAT/INVALID samples never overwrite it.
  typedef enum logic [1:0] {
    LAST_NONE = 2'b00,
    LAST_LOW  = 2'b01,
    LAST_HIGH = 2'b10
  } last_logic_t;

  // 100 ms gate window at 129.6 MHz.
  localparam int unsigned DEFAULT_WINDOW_CYCLES = 32'd12960000;

endpackage

// File: rtl/probe_sync2.sv
// Two-flop synchronizer for one asynchronous comparator output.
// Latency 2 cycles; no backpressure, samples every cycle.
// Both flops clear on synchronous active-low reset.
module probe_sync2 (
  input  logic clk,
  input  logic nreset,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      meta_q   <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta_q   <= async_in;
      sync_out <= meta_q;
    end
  end

endmodule

// File: rtl/logic_probe_sampler.sv
// Logic probe sampler: classifies comparator pair per cycle, accumulates class/edge counts per gate window.
// Latency: pin change classified 3 cycles later; results load on the window's last counted cycle.
// Backpressure: none on input; unacked result is overwritten at the next window end and flagged by overrun.
module logic_probe_sampler
  import logic_probe_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = DEFAULT_WINDOW_CYCLES,
  parameter int unsigned COUNT_BITS    = 24,
  parameter int unsigned WINDOW_BITS   = 24
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  comp_out_hi,
  input  logic                  comp_out_lo,
  input  logic                  enable,
  input  logic                  result_ack,
  output logic                  result_valid,
  output logic [COUNT_BITS-1:0] high_count,
  output logic [COUNT_BITS-1:0] low_count,
  output logic [COUNT_BITS-1:0] float_count,
  output logic [COUNT_BITS-1:0] invalid_count,
  output logic [COUNT_BITS-1:0] rise_count,
  output logic [COUNT_BITS-1:0] fall_count,
  output logic                  overrun
);

  logic                   hi_sync;
  logic                   lo_sync;
  level_t                 level_q;
  last_logic_t            last_q;
  logic [WINDOW_BITS-1:0] win_cnt;

  logic [COUNT_BITS-1:0]  high_acc, low_acc, float_acc, invalid_acc, rise_acc, fall_acc;
  logic [COUNT_BITS-1:0]  high_nxt, low_nxt, float_nxt, invalid_nxt, rise_nxt, fall_nxt;

  logic is_high, is_low, is_float, is_invalid;
  logic rise_evt, fall_evt;
  logic win_last, win_end;

  function automatic logic [COUNT_BITS-1:0] sat_inc(input logic [COUNT_BITS-1:0] v,
                                                    input logic inc);
    if (inc && (v != {COUNT_BITS{1'b1}}))
      return v + COUNT_BITS'(1);
    return v;
  endfunction

  probe_sync2 u_sync_hi (.clk(clk), .nreset(nreset), .async_in(comp_out_hi), .sync_out(hi_sync));
  probe_sync2 u_sync_lo (.clk(clk), .nreset(nreset), .async_in(comp_out_lo), .sync_out(lo_sync));

  always_ff @(posedge clk) begin
    if (!nreset) level_q <= LVL_FLOAT;
    else         level_q <= level_t'({hi_sync, lo_sync});
  end

  always_comb begin
    is_high    = (level_q == LVL_HIGH);
    is_low     = (level_q == LVL_LOW);
    is_float   = (level_q == LVL_FLOAT);
    is_invalid = (level_q == LVL_INVALID);
    rise_evt   = is_high && (last_q == LAST_LOW);
    fall_evt   = is_low  && (last_q == LAST_HIGH);

    high_nxt    = sat_inc(high_acc,    is_high);
    low_nxt     = sat_inc(low_acc,     is_low);
    float_nxt   = sat_inc(float_acc,   is_float);
    invalid_nxt = sat_inc(invalid_acc, is_invalid);
    rise_nxt    = sat_inc(rise_acc,    rise_evt);
    fall_nxt    = sat_inc(fall_acc,    fall_evt);

    win_last = (win_cnt == WINDOW_BITS'(WINDOW_CYCLES - 1));
    win_end  = enable && win_last;
  end

  // Disabled or reset: discard partial window and forget edge history.
  always_ff @(posedge clk) begin
    if (!nreset || !enable) begin
      high_acc    <= '0;
      low_acc     <= '0;
      float_acc   <= '0;
      invalid_acc <= '0;
      rise_acc    <= '0;
      fall_acc    <= '0;
      win_cnt     <= '0;
      last_q      <= LAST_NONE;
    end else begin
      if (is_high)     last_q <= LAST_HIGH;
      else if (is_low) last_q <= LAST_LOW;

      if (win_last) begin
        high_acc    <= '0;
        low_acc     <= '0;
        float_acc   <= '0;
        invalid_acc <= '0;
        rise_acc    <= '0;
        fall_acc    <= '0;
        win_cnt     <= '0;
      end else begin
        high_acc    <= high_nxt;
        low_acc     <= low_nxt;
        float_acc   <= float_nxt;
        invalid_acc <= invalid_nxt;
        rise_acc    <= rise_nxt;
        fall_acc    <= fall_nxt;
        win_cnt     <= win_cnt + WINDOW_BITS'(1);
      end
    end
  end

  // A window end always wins over an ack; same-cycle ack only suppresses overrun.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      result_valid  <= 1'b0;
      overrun       <= 1'b0;
      high_count    <= '0;
      low_count     <= '0;
      float_count   <= '0;
      invalid_count <= '0;
      rise_count    <= '0;
      fall_count    <= '0;
    end else if (win_end) begin
      result_valid  <= 1'b1;
      overrun       <= result_valid && !result_ack;
      high_count    <= high_nxt;
      low_count     <= low_nxt;
      float_count   <= float_nxt;
      invalid_count <= invalid_nxt;
      rise_count    <= rise_nxt;
      fall_count    <= fall_nxt;
    end else if (result_valid && result_ack) begin
      result_valid  <= 1'b0;
      overrun       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logic_probe_sampler.sv
// Directed bench for logic_probe_sampler with a 16-cycle window and 8-bit counters.
// Pins driven at tick k are counted at tick k+3, so each pattern's window result lands 3 ticks into the next pattern.
module tb_logic_probe_sampler;
  import logic_probe_pkg::*;

  localparam int unsigned WC = 16;
  localparam int unsigned CB = 8;

  logic          clk = 1'b0;
  logic          nreset;
  logic          comp_out_hi;
  logic          comp_out_lo;
  logic          enable;
  logic          result_ack;
  logic          result_valid;
  logic [CB-1:0] high_count, low_count, float_count, invalid_count, rise_count, fall_count;
  logic          overrun;

  int tests_run = 0;
  int tests_failed = 0;

  logic_probe_sampler #(.WINDOW_CYCLES(WC), .COUNT_BITS(CB), .WINDOW_BITS(8)) dut (
    .clk(clk), .nreset(nreset),
    .comp_out_hi(comp_out_hi), .comp_out_lo(comp_out_lo),
    .enable(enable), .result_ack(result_ack),
    .result_valid(result_valid),
    .high_count(high_count), .low_count(low_count),
    .float_count(float_count), .invalid_count(invalid_count),
    .rise_count(rise_count), .fall_count(fall_count),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pins(input level_t lvl);
    comp_out_hi = lvl[1];
    comp_out_lo = lvl[0];
  endtask

  // 16 ticks of pins in four 4-tick segments.
  task automatic run_win(input level_t s0, input level_t s1, input level_t s2, input level_t s3,
                         input int en_from, input int ack_at);
    level_t seg [4];
    seg[0] = s0; seg[1] = s1; seg[2] = s2; seg[3] = s3;
    for (int i = 0; i < 16; i++) begin
      set_pins(seg[i/4]);
      enable     = (i >= en_from);
      result_ack = (i == ack_at);
      tick();
    end
    result_ack = 1'b0;
  endtask

  task automatic check_counts(input string tag, input int h, input int l, input int f,
                              input int inv, input int r, input int fa);
    check_eq({tag, "_high"},    32'(high_count),    32'(h));
    check_eq({tag, "_low"},     32'(low_count),     32'(l));
    check_eq({tag, "_float"},   32'(float_count),   32'(f));
    check_eq({tag, "_invalid"}, 32'(invalid_count), 32'(inv));
    check_eq({tag, "_rise"},    32'(rise_count),    32'(r));
    check_eq({tag, "_fall"},    32'(fall_count),    32'(fa));
  endtask

  initial begin
    logic seen_valid;
    nreset = 1'b0; enable = 1'b0; result_ack = 1'b0;
    set_pins(LVL_HIGH);
    tick(); tick();
    check_eq("rst_valid", 32'(result_valid), 32'd0);
    check_eq("rst_overrun", 32'(overrun), 32'd0);
    check_counts("rst", 0, 0, 0, 0, 0, 0);
    nreset = 1'b1;

    // W0: constant HIGH, enable raised after pins settle.
    run_win(LVL_HIGH, LVL_HIGH, LVL_HIGH, LVL_HIGH, 3, -1);
    // W1: 12 HIGH then 4 LOW -> one fall; W0 result visible, no ack.
    run_win(LVL_HIGH, LVL_HIGH, LVL_HIGH, LVL_LOW, 0, -1);
    check_eq("w0_valid", 32'(result_valid), 32'd1);
    check_eq("w0_overrun", 32'(overrun), 32'd0);
    check_counts("w0", 16, 0, 0, 0, 0, 0);

    // W2: square wave starting LOW after a LOW-ending window; W1 overwrote unacked W0.
    run_win(LVL_LOW, LVL_HIGH, LVL_LOW, LVL_HIGH, 0, -1);
    check_eq("w1_valid", 32'(result_valid), 32'd1);
    check_eq("w1_overrun", 32'(overrun), 32'd1);
    check_counts("w1", 12, 4, 0, 0, 0, 1);

    // W3: square wave after HIGH-ending window; ack after W2 loads clears valid and overrun.
    run_win(LVL_LOW, LVL_HIGH, LVL_LOW, LVL_HIGH, 0, 6);
    check_eq("ack_valid", 32'(result_valid), 32'd0);
    check_eq("ack_overrun", 32'(overrun), 32'd0);
    check_counts("w2", 8, 8, 0, 0, 2, 1);

    // W4: constant HIGH; W3 loads fresh.
    run_win(LVL_HIGH, LVL_HIGH, LVL_HIGH, LVL_HIGH, 0, -1);
    check_eq("w3_valid", 32'(result_valid), 32'd1);
    check_eq("w3_overrun", 32'(overrun), 32'd0);
    check_counts("w3", 8, 8, 0, 0, 2, 2);

    // W5: ack lands exactly on W4's window-end cycle.
    run_win(LVL_HIGH, LVL_HIGH, LVL_LOW, LVL_LOW, 0, 2);
    check_eq("same_valid", 32'(result_valid), 32'd1);
    check_eq("same_overrun", 32'(overrun), 32'd0);
    check_counts("w4", 16, 0, 0, 0, 0, 0);

    // Enable drop at window cycle 7, re-enable 5 ticks later on constant HIGH.
    seen_valid = 1'b0;
    for (int i = 0; i <= 30; i++) begin
      set_pins(i <= 6 ? LVL_LOW : LVL_HIGH);
      enable     = !(i >= 10 && i <= 14);
      result_ack = (i == 12);
      tick();
      if (i == 12) begin
        check_eq("dis_ack_valid", 32'(result_valid), 32'd0);
        check_eq("dis_ack_overrun", 32'(overrun), 32'd0);
      end
      if (i >= 13 && i <= 29 && result_valid) seen_valid = 1'b1;
    end
    result_ack = 1'b0;
    check_eq("no_partial_result", 32'(seen_valid), 32'd0);
    check_eq("reen_valid", 32'(result_valid), 32'd1);
    check_counts("reen", 16, 0, 0, 0, 0, 0);

    // Reset mid-window while a result is pending.
    for (int i = 0; i < 5; i++) tick();
    nreset = 1'b0;
    tick();
    check_eq("mid_rst_valid", 32'(result_valid), 32'd0);
    check_eq("mid_rst_overrun", 32'(overrun), 32'd0);
    check_counts("mid_rst", 0, 0, 0, 0, 0, 0);
    nreset = 1'b1;

    // First window after reset: LOW, FLOAT, HIGH, INVALID.
    run_win(LVL_LOW, LVL_FLOAT, LVL_HIGH, LVL_INVALID, 3, -1);
    tick(); tick();
    check_eq("post_rst_early", 32'(result_valid), 32'd0);
    tick();
    check_eq("post_rst_valid", 32'(result_valid), 32'd1);
    check_counts("lfhi", 4, 4, 4, 4, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/logic_probe_sampler.md
Name: logic_probe_sampler

Overview:
- Front-end measurement stage of the logic probe. Consumes the two window-comparator outputs (comp_out_hi, comp_out_lo) on the fast probe clock.
- Each cycle, classifies the probed net as HIGH / LOW / FLOAT / INVALID, then accumulates per-class cycle counts and rising/falling edge counts over a fixed gate window.
- Hands each completed window's results to the CPU-side logic through a valid/ack handshake.

Parameters:
- WINDOW_CYCLES, 12960000, gate window length in clk cycles (100 ms at 129.6 MHz); must be ≥ 4.
- COUNT_BITS, 24, width of every result counter; must satisfy 2^COUNT_BITS > WINDOW_CYCLES.
- WINDOW_BITS, 24, width of the internal window counter; must satisfy 2^WINDOW_BITS > WINDOW_CYCLES.

Ports:
- clk  in  1  probe clock (clk_probe domain); the block's only clock.
- nreset  in  1  synchronous, active-low reset.
- comp_out_hi  in  1  asynchronous; 1 = probed voltage above the high threshold.
- comp_out_lo  in  1  asynchronous; 1 = probed voltage below the low threshold.
- enable  in  1  1 = measure; 0 = hold accumulators and edge history cleared.
- result_ack  in  1  consumer acknowledge; 1-cycle pulse while result_valid=1.
- result_valid  out  1  result registers hold an unacknowledged window.
- high_count  out  COUNT_BITS  cycles classified HIGH in the last window.
- low_count  out  COUNT_BITS  cycles classified LOW.
- float_count  out  COUNT_BITS  cycles classified FLOAT.
- invalid_count  out  COUNT_BITS  cycles classified INVALID.
- rise_count  out  COUNT_BITS  LOW→HIGH transitions.
- fall_count  out  COUNT_BITS  HIGH→LOW transitions.
- overrun  out  1  a window completed while result_valid was still 1.

Behaviour:
- Reset (nreset=0 at a rising clk edge): all outputs 0, sync flops 0, accumulators 0, window counter 0, last_logic=NONE. Reset mid-window discards the partial window.
- Input sync: each comparator passes through 2 flops. The classification register follows, so a pin change is classified 3 cycles later.
- Classification of the synced pair {hi,lo}: 10=HIGH, 01=LOW, 00=FLOAT, 11=INVALID.
- Edge tracking: last_logic ∈ {NONE, LOW, HIGH} updates only on HIGH or LOW samples; FLOAT and INVALID samples leave it unchanged.
  - HIGH with last_logic=LOW → rise +1.
  - LOW with last_logic=HIGH → fall +1.
  - The first HIGH/LOW after NONE counts no edge.
  - So LOW, FLOAT, HIGH counts as exactly one rise.
- Accumulation: while enable=1, each classified sample increments exactly one class accumulator. All accumulators saturate at all-ones and never wrap.
- Window counter: runs 0..WINDOW_CYCLES-1 while enable=1.
- Window end (cycle where the counter = WINDOW_CYCLES-1):
  - Output registers load the accumulator values including that cycle's sample; high+low+float+invalid = WINDOW_CYCLES.
  - Accumulators reset to 0 and the counter wraps to 0 on the same edge; no sample is lost or duplicated.
  - last_logic persists across windows, so an edge spanning the boundary counts in the new window.
- Handshake:
  - Window end → result_valid=1.
  - result_ack while result_valid=1 (no window end) → result_valid=0, overrun=0 next cycle.
  - result_ack while result_valid=0 → ignored.
  - Window end while result_valid=1 and no ack → results overwritten, overrun=1.
  - Window end and ack in the same cycle → new results loaded, result_valid stays 1, overrun=0.
  - Outputs are stable whenever result_valid=1 except at a window-end load.
- enable=0:
  - Clears accumulators and the window counter, and sets last_logic=NONE.
  - result_valid, the result registers and overrun are held; ack still works.
  - Deassert mid-window discards the partial window. On re-enable, the first counted sample is the cycle enable is seen high.
- Sync flops run regardless of enable.

Decomposition:
- Shared package logic_probe_pkg:
  - level_t enum: LVL_FLOAT=2'b00, LVL_LOW=2'b01, LVL_HIGH=2'b10, LVL_INVALID=2'b11.
  - last_logic encoding.
  - Default WINDOW_CYCLES constant.
- One natural sub-module: probe_sync2, a 2-flop synchronizer with sync active-low reset, instantiated once per comparator.

Test Plan (bench WINDOW_CYCLES=16, COUNT_BITS=8, WINDOW_BITS=8):
- hi=1, lo=0 held ≥3 cycles before enable=1 → after 16 cycles result_valid=1; high=16, all other counts 0, overrun=0.
- Square wave 4 LOW / 4 HIGH, phase-aligned so the window holds 8 LOW + 8 HIGH starting with LOW, last_logic=LOW at window start → high=8, low=8, rise=2, fall=1 (2 rises + 2 falls when the preceding window ended HIGH).
- Sequence LOW×4, FLOAT×4, HIGH×4, INVALID×4 → low=4, float=4, high=4, invalid=4, rise=1, fall=0.
- No ack for 2 windows → overrun=1, results = second window. Then ack → result_valid=0, overrun=0. Ack on the exact window-end cycle → result_valid=1, overrun=0.
- enable dropped at cycle 7 of a window, raised 5 cycles later with constant HIGH → no result for the partial window. Next result exactly 16 cycles after re-enable: high=16, rise=0.
- nreset=0 for 1 cycle mid-window with result_valid=1 → all outputs 0 next cycle; first new result 16 cycles after enable is seen high post-reset.
